mem_march_tester: RTL and testbench
===================================

Name: mem_march_tester

Overview:
- Initiator/controller for the team's single-port synchronous memory block.
- Drives addr/data/we into the memory and consumes its registered read data (1-cycle read latency).
- Runs a March C- style self-test over all MEM_DEPTH words and reports pass/fail, first failing address and error count.
- Used as on-chip BIST and as the bench driver for memory bring-up.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 8, memory address width.
- MEM_DEPTH, 256, number of words tested (1..2^ADDR_WIDTH).
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  single clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin test; sampled only in IDLE or DONE.
- bg_pattern  in  DATA_WIDTH  background word P, captured on the accepted start.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_wdata  out  DATA_WIDTH  to memory data_in.
- mem_we  out  1  to memory we.
- mem_rdata  in  DATA_WIDTH  from memory data_out (registered in memory).
- busy  out  1  test in progress.
- done  out  1  test complete; held until next accepted start.
- pass  out  1  done and err_count==0.
- fail_valid  out  1  at least one mismatch seen this run.
- fail_addr  out  ADDR_WIDTH  address of first mismatch.
- err_count  out  ERR_W  mismatch count, saturating.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, pass=0, fail_valid=0, fail_addr=0, err_count=0, state=IDLE.
- Memory-side outputs decode only from registered state, address counter and captured P. No input-to-output combinational path.
- States: IDLE, W0, E1_RD, E1_WR, E2_RD, E2_WR, E3_RD, E3_CHK, DONE.
- IDLE/DONE, start=1: capture P, clear err_count/fail_valid/fail_addr, done=0, counter=0, go to W0. busy=1 from next cycle.
- W0 (ascending): we=1, wdata=P, one address per cycle. After MEM_DEPTH-1, counter=0, go to E1_RD.
- E1 (ascending), per address A:
  - E1_RD: we=0, addr=A.
  - E1_WR: compare mem_rdata to P; we=1, addr=A, wdata=~P.
  - After the last address, counter=MEM_DEPTH-1, go to E2_RD.
- E2 (descending MEM_DEPTH-1 down to 0): same pair; expected ~P, writes P. After address 0, counter=0, go to E3_RD.
- E3 (ascending): E3_RD reads; E3_CHK compares to P with we=0. After the last address, go to DONE.
- DONE: busy=0, done=1, pass=(err_count==0), we=0.
- Timing: DONE is entered exactly 7*MEM_DEPTH edges after the start-accepting edge.
- Totals: 3*MEM_DEPTH writes, 3*MEM_DEPTH compares.
- Compare:
  - A mismatch increments err_count, saturating at all-ones.
  - The first mismatch sets fail_valid=1 and fail_addr=A; later mismatches do not change fail_addr.
- Read-during-write to the same address is never issued; reads and writes to A occupy separate cycles.
- start while busy is ignored. start held high in DONE restarts immediately.
- rst asserted mid-test: all outputs go to reset values immediately (asynchronous); memory contents are undefined for the next run.
- Counter wrap: never exceeds MEM_DEPTH-1. The descending element terminates at 0 without underflow.

Optional Feature:
- Macro: MARCH_STOP_ON_FAIL_EN.
- Defined: the first mismatch records error/fail_addr as normal, then the FSM goes to DONE on the next edge (we=0). err_count=1, pass=0.
- Undefined: the full march always completes and err_count counts all mismatches.

Test Plan:
- Clean run, P=8'h55, MEM_DEPTH=256, bench sync RAM with 1-cycle read -> done 1792 cycles after start, pass=1, err_count=0, 768 writes observed, first write data 8'h55, first E1 write 8'hAA.
- Bit0 of word 0x10 stuck-at-1 on read, P=8'h00 -> mismatches in E1 and E3 only; done at 1792, err_count=2, fail_valid=1, fail_addr=8'h10, pass=0.
- Stuck-at fault as above plus a second stuck-at-1 on word 0x20 -> fail_addr stays 8'h10, err_count=4.
- start pulsed again at cycle 500 -> ignored, done still at 1792. start held high through DONE -> new run begins, done drops next cycle.
- rst asserted during E2 -> busy=0, mem_we=0, err_count=0 without waiting for a clock edge. Rerun after release -> pass=1.
- MARCH_STOP_ON_FAIL_EN defined, stuck-at fault on word 0x10 -> done one cycle after the E1_WR compare at address 0x10, err_count=1, fail_addr=8'h10.

Source files
------------

// File: rtl/mem_march_tester_if.sv
// Memory-side bus between the march tester (master) and the single-port sync RAM (slave).
// Ports: mem_addr, mem_wdata, mem_we toward the RAM; mem_rdata (registered, 1-cycle) back.
interface mem_march_tester_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mem_march_tester.sv
// March C- style BIST controller for a single-port sync RAM with 1-cycle read latency.
// Ports: clk, rst (async, active-high), start, bg_pattern; bus (master modport: mem_addr,
// mem_wdata, mem_we out, mem_rdata in); status busy, done, pass, fail_valid, fail_addr,
// err_count. Optional macro MARCH_STOP_ON_FAIL_EN ends the run at the first mismatch.
module mem_march_tester #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int ERR_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  bg_pattern,
    mem_march_tester_if.master     bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   fail_valid,
    output logic [ADDR_WIDTH-1:0]  fail_addr,
    output logic [ERR_W-1:0]       err_count
);
    typedef enum logic [3:0] {
        IDLE, W0, E1_RD, E1_WR, E2_RD, E2_WR, E3_RD, E3_CHK, DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                r_state, w_state_n;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_n;
    logic [DATA_WIDTH-1:0] r_p, w_p_n;
    logic [ERR_W-1:0]      r_err, w_err_n;
    logic                  r_fv, w_fv_n;
    logic [ADDR_WIDTH-1:0] r_fa, w_fa_n;

    logic                  w_we;
    logic                  w_cmp;
    logic [DATA_WIDTH-1:0] w_exp;
    logic                  w_mis;

    // Memory side decodes from registered state only.
    assign w_we = (r_state == W0) || (r_state == E1_WR) || (r_state == E2_WR);
    assign bus.mem_we    = w_we;
    assign bus.mem_addr  = r_cnt;
    assign bus.mem_wdata = (r_state == E1_WR) ? ~r_p : (w_we ? r_p : '0);

    // Read data for the address issued in the *_RD cycle arrives in the following cycle.
    assign w_cmp = (r_state == E1_WR) || (r_state == E2_WR) || (r_state == E3_CHK);
    assign w_exp = (r_state == E2_WR) ? ~r_p : r_p;
    assign w_mis = w_cmp && (bus.mem_rdata != w_exp);

    assign busy       = (r_state != IDLE) && (r_state != DONE);
    assign done       = (r_state == DONE);
    assign pass       = done && (r_err == '0);
    assign fail_valid = r_fv;
    assign fail_addr  = r_fa;
    assign err_count  = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_p     <= '0;
            r_err   <= '0;
            r_fv    <= 1'b0;
            r_fa    <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_p     <= w_p_n;
            r_err   <= w_err_n;
            r_fv    <= w_fv_n;
            r_fa    <= w_fa_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_p_n     = r_p;
        w_err_n   = r_err;
        w_fv_n    = r_fv;
        w_fa_n    = r_fa;

        if (w_mis) begin
            if (r_err != '1) w_err_n = r_err + 1'b1;
            if (!r_fv) begin
                w_fv_n = 1'b1;
                w_fa_n = r_cnt;
            end
        end

        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_n = W0;
                    w_cnt_n   = '0;
                    w_p_n     = bg_pattern;
                    w_err_n   = '0;
                    w_fv_n    = 1'b0;
                    w_fa_n    = '0;
                end
            end
            W0: begin
                if (r_cnt == LAST) begin
                    w_cnt_n   = '0;
                    w_state_n = E1_RD;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            E1_RD: w_state_n = E1_WR;
            E1_WR: begin
                if (r_cnt == LAST) begin
                    w_cnt_n   = LAST;
                    w_state_n = E2_RD;
                end else begin
                    w_cnt_n   = r_cnt + 1'b1;
                    w_state_n = E1_RD;
                end
            end
            E2_RD: w_state_n = E2_WR;
            E2_WR: begin
                // Descending element stops at 0 rather than wrapping.
                if (r_cnt == '0) begin
                    w_state_n = E3_RD;
                end else begin
                    w_cnt_n   = r_cnt - 1'b1;
                    w_state_n = E2_RD;
                end
            end
            E3_RD: w_state_n = E3_CHK;
            E3_CHK: begin
                if (r_cnt == LAST) begin
                    w_state_n = DONE;
                end else begin
                    w_cnt_n   = r_cnt + 1'b1;
                    w_state_n = E3_RD;
                end
            end
            default: w_state_n = IDLE;
        endcase

`ifdef MARCH_STOP_ON_FAIL_EN
        if (w_mis) w_state_n = DONE;
`else
        // Full march always runs to completion.
`endif
    end
endmodule

// File: tb/tb_mem_march_tester.sv
// Scoreboard bench for mem_march_tester: sync RAM with stuck-at-1 read faults,
// expected writes and run results queued by the driver and checked by a monitor.
module tb_mem_march_tester;
    localparam int N = 256;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        int         lat;
        int         err;
        int         fv;
        logic [7:0] fa;
        int         pass;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bg = 8'h00;
    logic        busy, done, pass, fail_valid;
    logic [7:0]  fail_addr;
    logic [15:0] err_count;

    mem_march_tester_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    mem_march_tester dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bg_pattern (bg),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_valid (fail_valid),
        .fail_addr  (fail_addr),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, stuck-at-1 bits applied on read.
    logic [7:0] ram   [N];
    logic [7:0] stuck [N];
    logic [7:0] rd_q = 8'h00;
    assign bus.mem_rdata = rd_q;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        rd_q <= ram[bus.mem_addr] | stuck[bus.mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    int   t_start = 0;
    wr_t  wq[$];
    res_t rq[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the march as three read elements over the fault map.
    task automatic build_expect(input logic [7:0] p);
        res_t r;
        r.lat = 7 * N;
        r.err = 0;
        r.fv  = 0;
        r.fa  = 8'h00;
        for (int i = 0; i < N; i++) wq.push_back('{8'(i), p});
        for (int k = 0; k < 3 * N; k++) begin
            int ph, j;
            logic [7:0] a, e;
            ph = k / N;
            j  = k % N;
            a  = (ph == 1) ? 8'(N - 1 - j) : 8'(j);
            e  = (ph == 1) ? ~p : p;
            if (ph < 2) wq.push_back('{a, (ph == 0) ? ~p : p});
            if ((e | stuck[a]) != e) begin
                if (r.fv == 0) r.fa = a;
                r.fv = 1;
                r.err++;
`ifdef MARCH_STOP_ON_FAIL_EN
                r.lat = N + 2 * (k + 1);
                break;
`endif
            end
        end
        r.pass = (r.err == 0) ? 1 : 0;
        rq.push_back(r);
    endtask

    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            done_q = 1'b0;
        end else begin
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", bus.mem_addr, w.a);
                    chk("wr_data", bus.mem_wdata, w.d);
                end
            end
            if (done && !done_q) begin
                if (rq.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    chk("latency", cyc - t_start, r.lat);
                    chk("err_count", err_count, r.err);
                    chk("fail_valid", fail_valid, r.fv);
                    chk("fail_addr", fail_addr, r.fa);
                    chk("pass", pass, r.pass);
                    chk("busy_at_done", busy, 0);
                end
            end
            done_q = done;
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < N; i++) stuck[i] = 8'h00;
    endtask

    task automatic kick(input logic [7:0] p, input bit hold);
        build_expect(p);
        @(negedge clk);
        start   = 1'b1;
        bg      = p;
        t_start = cyc + 1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        bg = 8'($urandom);
    endtask

    task automatic wait_done(input bit hold, input int poke);
        int got;
        got = 0;
        for (int i = 1; i <= 7 * N + 20; i++) begin
            @(negedge clk);
            if (poke != 0 && i == poke) start = 1'b1;
            else if (!hold) start = 1'b0;
            if (done) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", got, 1);
        #2;
    endtask

    initial begin
        logic [7:0] p2;
        int exp_pre;
        clear_faults();
        for (int i = 0; i < N; i++) ram[i] = 8'($urandom);
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fv", fail_valid, 0);
        chk("rst_fa", fail_addr, 0);
        chk("rst_err", err_count, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // Clean run.
        kick(8'h55, 1'b0);
        wait_done(1'b0, 0);

        // Single stuck bit, with a start pulse mid-run that must be ignored.
        stuck[8'h10] = 8'h01;
        kick(8'h00, 1'b0);
        wait_done(1'b0, 500);

        // Second fault at a higher address.
        stuck[8'h20] = 8'h01;
        kick(8'h00, 1'b0);
        wait_done(1'b0, 0);

        // start held through DONE restarts on the next edge.
        clear_faults();
        kick(8'($urandom), 1'b1);
        wait_done(1'b1, 0);
        p2 = 8'($urandom);
        build_expect(p2);
        bg      = p2;
        t_start = cyc + 1;
        @(negedge clk);
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 1);
        start = 1'b0;
        wait_done(1'b0, 0);

        // Asynchronous reset in the middle of E2.
`ifdef MARCH_STOP_ON_FAIL_EN
        exp_pre = 0;
`else
        stuck[8'h10] = 8'h01;
        exp_pre = 1;
`endif
        kick(8'h00, 1'b0);
        repeat (3 * N + 40) @(negedge clk);
        chk("err_before_rst", err_count, exp_pre);
        chk("busy_before_rst", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_we", bus.mem_we, 0);
        chk("arst_err", err_count, 0);
        chk("arst_fv", fail_valid, 0);
        chk("arst_done", done, 0);
        wq.delete();
        rq.delete();
        @(negedge clk);
        rst = 1'b0;
        clear_faults();
        kick(8'($urandom), 1'b0);
        wait_done(1'b0, 0);

        // Random patterns and random stuck-at-1 fault maps.
        for (int r = 0; r < 4; r++) begin
            int nf;
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++)
                stuck[$urandom_range(0, N - 1)] |= 8'(1 << $urandom_range(0, 7));
            kick(8'($urandom), 1'b0);
            wait_done(1'b0, 0);
        end

        repeat (4) @(negedge clk);
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
